// File: rtl/hdmi_pkg.sv
// Shared constants for the HDMI capture path: coordinate/luma widths and the
// fixed-point BT.601-style luma weights used by the capture pipeline.
package hdmi_pkg;

   localparam int HDMI_COORD_WIDTH = 12;
   localparam int LUMA_WIDTH       = 8;

   localparam logic [7:0] LUMA_COEF_R = 8'd77;
   localparam logic [7:0] LUMA_COEF_G = 8'd150;
   localparam logic [7:0] LUMA_COEF_B = 8'd29;
   localparam int         LUMA_SHIFT  = 8;

   // Weights sum to 256, so the 16-bit sum cannot overflow for 8-bit inputs.
   function automatic logic [LUMA_WIDTH-1:0] rgb_luma(input logic [7:0] r,
                                                      input logic [7:0] g,
                                                      input logic [7:0] b);
      logic [15:0] sum_v;
      sum_v = 16'(r) * 16'(LUMA_COEF_R)
            + 16'(g) * 16'(LUMA_COEF_G)
            + 16'(b) * 16'(LUMA_COEF_B);
      return sum_v[LUMA_SHIFT +: LUMA_WIDTH];
   endfunction

endpackage

// File: rtl/rgb_to_luma.sv
// Registered RGB888 to 8-bit luma converter; the result only updates when
// en_i is high so the downstream write data holds between writes.
module rgb_to_luma
   import hdmi_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  en_i,
   input  logic [7:0]            r_i,
   input  logic [7:0]            g_i,
   input  logic [7:0]            b_i,
   output logic [LUMA_WIDTH-1:0] luma_o
);

   logic [LUMA_WIDTH-1:0] luma_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         luma_q <= '0;
      end else if (en_i) begin
         luma_q <= rgb_luma(r_i, g_i, b_i);
      end
   end

   assign luma_o = luma_q;

endmodule

// File: rtl/hdmi_window_capture.sv
// Crops a WIDTH x HEIGHT window from the HDMI pixel stream, writes luma into a
// ping-pong framebuffer and swaps banks only after a frame with exactly one hit per pixel.
module hdmi_window_capture
   import hdmi_pkg::*;
#(
   parameter int MIN_X      = 50,
   parameter int MIN_Y      = 100,
   parameter int WIDTH      = 128,
   parameter int HEIGHT     = 32,
   parameter int ADDR_WIDTH = 12
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        rgb_valid,
   input  logic [HDMI_COORD_WIDTH-1:0] xaddr,
   input  logic [HDMI_COORD_WIDTH-1:0] yaddr,
   input  logic                        vsync,
   input  logic [7:0]                  r,
   input  logic [7:0]                  g,
   input  logic [7:0]                  b,
   output logic                        wr_en,
   output logic [ADDR_WIDTH:0]         wr_addr,
   output logic [LUMA_WIDTH-1:0]       wr_data,
   output logic                        read_bank,
   output logic                        frame_done,
   output logic [7:0]                  frame_count,
   output logic [7:0]                  drop_count
);

   localparam int DX_W      = $clog2(WIDTH);
   localparam int DY_W      = $clog2(HEIGHT);
   localparam int CNT_W     = ADDR_WIDTH + 1;
   localparam int FRAME_PIX = WIDTH * HEIGHT;

   localparam logic [HDMI_COORD_WIDTH-1:0] X_LO = HDMI_COORD_WIDTH'(MIN_X);
   localparam logic [HDMI_COORD_WIDTH-1:0] X_HI = HDMI_COORD_WIDTH'(MIN_X + WIDTH);
   localparam logic [HDMI_COORD_WIDTH-1:0] Y_LO = HDMI_COORD_WIDTH'(MIN_Y);
   localparam logic [HDMI_COORD_WIDTH-1:0] Y_HI = HDMI_COORD_WIDTH'(MIN_Y + HEIGHT);
   localparam logic [CNT_W-1:0]            CNT_FULL = CNT_W'(FRAME_PIX);
   localparam logic [CNT_W-1:0]            CNT_SAT  = CNT_W'(FRAME_PIX + 1);

   logic                        hit_s;
   logic                        rise_s;
   logic [HDMI_COORD_WIDTH-1:0] dx_full_s;
   logic [HDMI_COORD_WIDTH-1:0] dy_full_s;
   logic [CNT_W-1:0]            count_eval_s;

   logic            s1_hit_q;
   logic [DX_W-1:0] s1_dx_q;
   logic [DY_W-1:0] s1_dy_q;
   logic [7:0]      s1_r_q;
   logic [7:0]      s1_g_q;
   logic [7:0]      s1_b_q;
   logic            s1_bank_q;

   logic                  wr_en_q;
   logic [ADDR_WIDTH:0]   wr_addr_q;
   logic [LUMA_WIDTH-1:0] luma_s;

   logic             vsync_q;
   logic [CNT_W-1:0] count_q,       count_d;
   logic             read_bank_q,   read_bank_d;
   logic             frame_done_q,  frame_done_d;
   logic [7:0]       frame_count_q, frame_count_d;
   logic [7:0]       drop_count_q,  drop_count_d;

   assign hit_s = rgb_valid
                && (xaddr >= X_LO) && (xaddr < X_HI)
                && (yaddr >= Y_LO) && (yaddr < Y_HI);
   assign dx_full_s = xaddr - X_LO;
   assign dy_full_s = yaddr - Y_LO;
   assign rise_s    = vsync && !vsync_q;

   // Stage 1: capture the hit with its offsets, colour and destination bank.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_hit_q  <= 1'b0;
         s1_dx_q   <= '0;
         s1_dy_q   <= '0;
         s1_r_q    <= 8'd0;
         s1_g_q    <= 8'd0;
         s1_b_q    <= 8'd0;
         s1_bank_q <= 1'b0;
      end else begin
         s1_hit_q <= hit_s;
         if (hit_s) begin
            s1_dx_q   <= dx_full_s[DX_W-1:0];
            s1_dy_q   <= dy_full_s[DY_W-1:0];
            s1_r_q    <= r;
            s1_g_q    <= g;
            s1_b_q    <= b;
            s1_bank_q <= ~read_bank_q;
         end
      end
   end

   // Stage 2: write strobe and address, aligned with the registered luma.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
      end else begin
         wr_en_q <= s1_hit_q;
         if (s1_hit_q) begin
            wr_addr_q <= {s1_bank_q, s1_dy_q, s1_dx_q};
         end
      end
   end

   rgb_to_luma u_luma (
      .clk_i   (clk),
      .rst_n_i (reset),
      .en_i    (s1_hit_q),
      .r_i     (s1_r_q),
      .g_i     (s1_g_q),
      .b_i     (s1_b_q),
      .luma_o  (luma_s)
   );

   // A hit coinciding with the vsync edge belongs to the frame being judged.
   always_comb begin
      count_d       = count_q;
      read_bank_d   = read_bank_q;
      frame_done_d  = 1'b0;
      frame_count_d = frame_count_q;
      drop_count_d  = drop_count_q;
      if (hit_s && (count_q != CNT_SAT)) begin
         count_eval_s = count_q + CNT_W'(1);
      end else begin
         count_eval_s = count_q;
      end
      if (rise_s) begin
         count_d = '0;
         if (count_eval_s == CNT_FULL) begin
            read_bank_d   = ~read_bank_q;
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + 8'd1;
         end else if (drop_count_q != 8'hFF) begin
            drop_count_d = drop_count_q + 8'd1;
         end else begin
            drop_count_d = drop_count_q;
         end
      end else begin
         count_d = count_eval_s;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vsync_q       <= 1'b0;
         count_q       <= '0;
         read_bank_q   <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_count_q <= 8'd0;
         drop_count_q  <= 8'd0;
      end else begin
         vsync_q       <= vsync;
         count_q       <= count_d;
         read_bank_q   <= read_bank_d;
         frame_done_q  <= frame_done_d;
         frame_count_q <= frame_count_d;
         drop_count_q  <= drop_count_d;
      end
   end

   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = luma_s;
   assign read_bank   = read_bank_q;
   assign frame_done  = frame_done_q;
   assign frame_count = frame_count_q;
   assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_hdmi_window_capture.sv
// Directed bench for hdmi_window_capture: window hits and misses, luma values,
// bank swapping on complete frames, drop accounting and asynchronous reset.
module tb_hdmi_window_capture;

   logic        clk;
   logic        reset;
   logic        rgb_valid;
   logic [11:0] xaddr;
   logic [11:0] yaddr;
   logic        vsync;
   logic [7:0]  r;
   logic [7:0]  g;
   logic [7:0]  b;
   logic        wr_en;
   logic [12:0] wr_addr;
   logic [7:0]  wr_data;
   logic        read_bank;
   logic        frame_done;
   logic [7:0]  frame_count;
   logic [7:0]  drop_count;

   int checks   = 0;
   int failures = 0;

   hdmi_window_capture dut (
      .clk         (clk),
      .reset       (reset),
      .rgb_valid   (rgb_valid),
      .xaddr       (xaddr),
      .yaddr       (yaddr),
      .vsync       (vsync),
      .r           (r),
      .g           (g),
      .b           (b),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .read_bank   (read_bank),
      .frame_done  (frame_done),
      .frame_count (frame_count),
      .drop_count  (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int x, input int y, input logic [7:0] rr,
                        input logic [7:0] gg, input logic [7:0] bb);
      rgb_valid = 1'b1;
      xaddr = 12'(x);
      yaddr = 12'(y);
      r = rr;
      g = gg;
      b = bb;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      rgb_valid = 1'b0;
      vsync = 1'b0;
      xaddr = 12'd0;
      yaddr = 12'd0;
      r = 8'd0;
      g = 8'd0;
      b = 8'd0;
      step();
      step();
      reset = 1'b1;
      step();
   endtask

   // Raster-order window pixels; dup repeats the first pixel once.
   task automatic send_pixels(input int n, input bit dup);
      for (int i = 0; i < n; i++) begin
         drive(50 + (i % 128), 100 + (i / 128), 8'(i), 8'(i >> 3), 8'(i >> 5));
         step();
         if (dup && i == 0) step();
      end
      rgb_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      rgb_valid = 1'b0;
      vsync = 1'b0;
      step();
      checks++;
      if ({wr_en, wr_addr, wr_data, read_bank, frame_done, frame_count, drop_count} !== 39'd0) begin
         failures++;
         $display("FAIL reset_outputs: got en=%b addr=%h data=%h bank=%b done=%b fc=%0d dc=%0d, want all 0",
                  wr_en, wr_addr, wr_data, read_bank, frame_done, frame_count, drop_count);
      end
      apply_reset();
   endtask

   task automatic test_single_pixel();
      apply_reset();
      drive(50, 100, 8'hFF, 8'hFF, 8'hFF);
      step();
      rgb_valid = 1'b0;
      checks++;
      if (wr_en !== 1'b0) begin
         failures++;
         $display("FAIL latency_early: wr_en=%b after 1 clk, want 0", wr_en);
      end
      step();
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 13'h1000 || wr_data !== 8'hFF) begin
         failures++;
         $display("FAIL white_origin: en=%b addr=%h data=%h, want 1 1000 ff", wr_en, wr_addr, wr_data);
      end
      step();
      checks++;
      if (wr_en !== 1'b0 || wr_addr !== 13'h1000 || wr_data !== 8'hFF) begin
         failures++;
         $display("FAIL hold_after_write: en=%b addr=%h data=%h, want 0 1000 ff", wr_en, wr_addr, wr_data);
      end
      drive(177, 131, 8'h00, 8'hFF, 8'h00);
      step();
      rgb_valid = 1'b0;
      step();
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 13'h1FFF || wr_data !== 8'h95) begin
         failures++;
         $display("FAIL green_corner: en=%b addr=%h data=%h, want 1 1fff 95", wr_en, wr_addr, wr_data);
      end
      drive(51, 101, 8'h10, 8'h20, 8'h30);
      step();
      rgb_valid = 1'b0;
      step();
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 13'h1081 || wr_data !== 8'h1D) begin
         failures++;
         $display("FAIL mixed_colour: en=%b addr=%h data=%h, want 1 1081 1d", wr_en, wr_addr, wr_data);
      end
      drive(60, 110, 8'h00, 8'h00, 8'h00);
      step();
      rgb_valid = 1'b0;
      step();
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 13'h150A || wr_data !== 8'h00) begin
         failures++;
         $display("FAIL black_pixel: en=%b addr=%h data=%h, want 1 150a 00", wr_en, wr_addr, wr_data);
      end
   endtask

   task automatic test_misses();
      int xs[4] = '{49, 178, 50, 50};
      int ys[4] = '{100, 100, 99, 132};
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         drive(xs[k], ys[k], 8'hFF, 8'hFF, 8'hFF);
         step();
         rgb_valid = 1'b0;
         step();
         checks++;
         if (wr_en !== 1'b0) begin
            failures++;
            $display("FAIL miss_%0d_%0d: wr_en=%b, want 0", xs[k], ys[k], wr_en);
         end
      end
      drive(60, 110, 8'hFF, 8'hFF, 8'hFF);
      rgb_valid = 1'b0;
      step();
      step();
      checks++;
      if (wr_en !== 1'b0) begin
         failures++;
         $display("FAIL miss_invalid: wr_en=%b, want 0", wr_en);
      end
   endtask

   task automatic test_full_frame();
      apply_reset();
      send_pixels(4096, 1'b0);
      vsync = 1'b1;
      step();
      checks++;
      if (frame_done !== 1'b1 || read_bank !== 1'b1 || frame_count !== 8'd1 || drop_count !== 8'd0) begin
         failures++;
         $display("FAIL full_frame_swap: done=%b bank=%b fc=%0d dc=%0d, want 1 1 1 0",
                  frame_done, read_bank, frame_count, drop_count);
      end
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 13'h1FFF || wr_data !== 8'hF0) begin
         failures++;
         $display("FAIL full_frame_last_px: en=%b addr=%h data=%h, want 1 1fff f0", wr_en, wr_addr, wr_data);
      end
      vsync = 1'b0;
      step();
      checks++;
      if (frame_done !== 1'b0 || read_bank !== 1'b1) begin
         failures++;
         $display("FAIL frame_done_pulse: done=%b bank=%b, want 0 1", frame_done, read_bank);
      end
      drive(50, 100, 8'hFF, 8'hFF, 8'hFF);
      step();
      rgb_valid = 1'b0;
      step();
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 13'h0000) begin
         failures++;
         $display("FAIL next_frame_bank0: en=%b addr=%h, want 1 0000", wr_en, wr_addr);
      end
   endtask

   task automatic test_short_frame();
      apply_reset();
      send_pixels(4095, 1'b0);
      vsync = 1'b1;
      step();
      checks++;
      if (frame_done !== 1'b0 || read_bank !== 1'b0 || drop_count !== 8'd1 || frame_count !== 8'd0) begin
         failures++;
         $display("FAIL short_frame: done=%b bank=%b dc=%0d fc=%0d, want 0 0 1 0",
                  frame_done, read_bank, drop_count, frame_count);
      end
      vsync = 1'b0;
      step();
      for (int k = 0; k < 300; k++) begin
         vsync = 1'b1;
         step();
         vsync = 1'b0;
         step();
      end
      checks++;
      if (drop_count !== 8'd255 || read_bank !== 1'b0 || frame_count !== 8'd0) begin
         failures++;
         $display("FAIL drop_saturate: dc=%0d bank=%b fc=%0d, want 255 0 0", drop_count, read_bank, frame_count);
      end
   endtask

   task automatic test_dup_frame();
      apply_reset();
      send_pixels(4096, 1'b1);
      vsync = 1'b1;
      step();
      checks++;
      if (frame_done !== 1'b0 || read_bank !== 1'b0 || drop_count !== 8'd1 || frame_count !== 8'd0) begin
         failures++;
         $display("FAIL dup_frame: done=%b bank=%b dc=%0d fc=%0d, want 0 0 1 0",
                  frame_done, read_bank, drop_count, frame_count);
      end
      vsync = 1'b0;
      step();
   endtask

   task automatic test_vsync_coincide();
      apply_reset();
      send_pixels(4095, 1'b0);
      drive(177, 131, 8'h00, 8'hFF, 8'h00);
      vsync = 1'b1;
      step();
      rgb_valid = 1'b0;
      checks++;
      if (frame_done !== 1'b1 || read_bank !== 1'b1 || frame_count !== 8'd1) begin
         failures++;
         $display("FAIL coincide_counted: done=%b bank=%b fc=%0d, want 1 1 1", frame_done, read_bank, frame_count);
      end
      step();
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 13'h1FFF || wr_data !== 8'h95 || frame_done !== 1'b0) begin
         failures++;
         $display("FAIL coincide_old_bank: en=%b addr=%h data=%h done=%b, want 1 1fff 95 0",
                  wr_en, wr_addr, wr_data, frame_done);
      end
      for (int k = 0; k < 5; k++) step();
      checks++;
      if (frame_count !== 8'd1 || drop_count !== 8'd0 || read_bank !== 1'b1) begin
         failures++;
         $display("FAIL vsync_held: fc=%0d dc=%0d bank=%b, want 1 0 1", frame_count, drop_count, read_bank);
      end
      vsync = 1'b0;
      step();
   endtask

   task automatic test_async_reset();
      apply_reset();
      send_pixels(4096, 1'b0);
      vsync = 1'b1;
      step();
      vsync = 1'b0;
      step();
      send_pixels(200, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({wr_en, wr_addr, wr_data, read_bank, frame_done, frame_count, drop_count} !== 39'd0) begin
         failures++;
         $display("FAIL async_reset: en=%b addr=%h data=%h bank=%b done=%b fc=%0d dc=%0d, want all 0",
                  wr_en, wr_addr, wr_data, read_bank, frame_done, frame_count, drop_count);
      end
      step();
      reset = 1'b1;
      step();
      send_pixels(4096, 1'b0);
      vsync = 1'b1;
      step();
      checks++;
      if (frame_done !== 1'b1 || read_bank !== 1'b1 || frame_count !== 8'd1 || drop_count !== 8'd0) begin
         failures++;
         $display("FAIL after_reset_frame: done=%b bank=%b fc=%0d dc=%0d, want 1 1 1 0",
                  frame_done, read_bank, frame_count, drop_count);
      end
      vsync = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_single_pixel();
      test_misses();
      test_full_frame();
      test_short_frame();
      test_dup_frame();
      test_vsync_coincide();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
